tlb_ctrl: RTL and testbench
===========================

# tlb_ctrl

Lookup/refill controller sitting directly upstream of the TLB storage array. Accepts one virtual-address translation request at a time and drives the storage read port to compare the indexed set. On a hit it pulses the storage LRU-update port and returns the physical address. On a miss it issues a page-table-walk request, selects a victim way and writes the refilled entry into storage. It also performs a full invalidate (flush) by sweeping every entry through the storage write port.

## Interface
Parameters (values from tlb_params.vh):
- NUM_SETS, 16: sets in storage.
- NUM_WAYS, 4: ways per set; maximum 4, because the storage way select is 2 bits.
- SET_INDEX_BITS, 4: log2(NUM_SETS).
- LRU_BITS, 4: width of each way's use counter.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req_valid / req_ready  in / out  1 / 1: translation request handshake.
- req_vaddr  in  32: virtual address. VPN = [31:12], set index = VPN[SET_INDEX_BITS-1:0].
- req_write  in  1: 1 = store access (needs perms[1]); 0 = load access (needs perms[0]).
- resp_valid / resp_ready  out / in  1 / 1: response handshake.
- resp_paddr  out  32: {PPN, vaddr[11:0]}. Equals 0 when resp_fault is 1.
- resp_fault  out  1: permission fault or walk fault.
- rd_set_index  out  SET_INDEX_BITS: to storage.
- rd_valid  in  NUM_WAYS: from storage, way w at bit w.
- rd_vpn, rd_ppn  in  NUM_WAYS*20 each: way w at [w*20 +: 20].
- rd_perms  in  NUM_WAYS*2: way w at [w*2 +: 2].
- rd_lru_count  in  NUM_WAYS*LRU_BITS: way w at [w*LRU_BITS +: LRU_BITS].
- wr_en, wr_set_index, wr_way[1:0], wr_valid, wr_vpn[19:0], wr_ppn[19:0], wr_perms[1:0], wr_lru_count  out: storage write port.
- lru_update_en, lru_set_index, lru_way[1:0]  out: storage LRU increment port.
- ptw_req_valid / ptw_req_ready  out / in  1: walk request handshake.
- ptw_vpn  out  20: VPN for the walk.
- ptw_resp_valid  in  1: single-cycle pulse. ptw_ppn[19:0], ptw_perms[1:0] and ptw_fault are valid with it.
- flush_req  in  1: level signal. Sampled only in IDLE.
- flush_done  out  1: one-cycle pulse at the end of a sweep.

## Operation
States: IDLE, LOOKUP, PTW_REQ, PTW_WAIT, REFILL, RESP, FLUSH.

IDLE
- req_ready = 1 only in IDLE and only when flush_req = 0.
- flush_req has priority over req_valid.
- On req_valid & req_ready: latch vaddr and write flag, then go to LOOKUP.

LOOKUP
- rd_set_index = latched set. The storage read is combinational, so the compare happens in this cycle.
- Hit = rd_valid[w] & rd_vpn[w] == VPN. A hit in more than one way is illegal; the lowest matching way is used.
- Hit with permission OK:
  - Latch PPN.
  - Pulse lru_update_en for the hit way, except when that way's count is all-ones (the counter saturates and the storage adder must never wrap).
  - Go to RESP.
- Hit with permission denied: resp_fault = 1, no LRU update, go to RESP.
- Miss:
  - Victim = lowest-index invalid way.
  - If all ways are valid, victim = way with the minimum rd_lru_count; ties go to the lowest index.
  - Latch the victim, then go to PTW_REQ.

PTW_REQ
- ptw_req_valid = 1 and ptw_vpn held stable until ptw_req_ready; then go to PTW_WAIT.

PTW_WAIT
- On ptw_resp_valid with ptw_fault = 1: resp_fault = 1, no storage write, go to RESP.
- On ptw_resp_valid with ptw_fault = 0: latch ppn and perms, go to REFILL.

REFILL
- One-cycle wr_en with wr_valid = 1, VPN, PPN, perms and wr_lru_count = 1 into {set, victim}.
- Then run the permission check against the walked perms: fault or PPN into the response, go to RESP.

RESP
- resp_valid = 1, with paddr and fault held until resp_ready; then go to IDLE.

FLUSH
- A counter over NUM_SETS*NUM_WAYS entries writes wr_valid = 0 and all other fields 0, one entry per cycle: way in the low bits, set in the high bits.
- After the last entry: flush_done pulse, go to IDLE.

Arbitration and outputs
- wr_en and lru_update_en are never asserted in the same cycle.
- All storage write/LRU outputs are 0 when not in use.

## Timing
- Reset (async assert, sync deassert of the FSM): state IDLE and every output 0, except req_ready = 1 once rst_n is high.
- Reset asserted mid-operation aborts the request.
  - No wr_en or lru_update_en is emitted afterwards.
  - An outstanding walk response arriving in IDLE is ignored.
- Hit: accept at cycle 0, LOOKUP/lru_update_en at cycle 1, resp_valid from cycle 2. Back-to-back throughput is 1 request per 3 cycles.
- Miss: resp_valid appears 2 cycles after the ptw_resp_valid pulse on the success path, or 1 cycle after it on the fault path.
- Flush: NUM_SETS*NUM_WAYS + 1 cycles from acceptance to flush_done (65 cycles at the defaults).
- flush_req asserted during a request is serviced only after the response handshake completes.

## Test plan
- Cold miss: vaddr 0x0001_2345, read. Expect:
  - ptw_vpn = 0x00012.
  - Reply ppn 0xABCDE, perms 2'b01 → wr_en to set 2, way 0, lru 1.
  - resp_paddr = 0xABCD_E345, fault 0.
- Repeat the same vaddr. Expect:
  - No ptw_req_valid.
  - lru_update_en for set 2, way 0 at cycle 1.
  - resp_valid at cycle 2, same paddr.
- Store to the same page (perms 2'b01). Expect resp_fault = 1, paddr 0, no lru_update_en.
- Set full with counts {3,1,1,5}, miss in that set. Expect the victim to be way 1. Also check that a way at count 4'hF gets no lru_update_en on a hit.
- Walk fault, plus resp_ready held low for 5 cycles. Expect:
  - No wr_en.
  - resp_fault = 1 held stable.
  - req_ready = 0 until the response handshake completes.
- Flush: expect 64 wr_en cycles with wr_valid = 0 covering all {set, way} pairs, then flush_done. Then assert rst_n low mid-walk: outputs go to 0 immediately, and no write follows.

Source files
------------

// File: rtl/tlb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ctrl_if
// Description : Request/response, TLB storage and page-walk bundle for tlb_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_ctrl_if #(
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 4
) ();
    logic                           req_valid;
    logic                           req_ready;
    logic [31:0]                    req_vaddr;
    logic                           req_write;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [31:0]                    resp_paddr;
    logic                           resp_fault;
    logic [SET_INDEX_BITS-1:0]      rd_set_index;
    logic [NUM_WAYS-1:0]            rd_valid;
    logic [NUM_WAYS*20-1:0]         rd_vpn;
    logic [NUM_WAYS*20-1:0]         rd_ppn;
    logic [NUM_WAYS*2-1:0]          rd_perms;
    logic [NUM_WAYS*LRU_BITS-1:0]   rd_lru_count;
    logic                           wr_en;
    logic [SET_INDEX_BITS-1:0]      wr_set_index;
    logic [1:0]                     wr_way;
    logic                           wr_valid;
    logic [19:0]                    wr_vpn;
    logic [19:0]                    wr_ppn;
    logic [1:0]                     wr_perms;
    logic [LRU_BITS-1:0]            wr_lru_count;
    logic                           lru_update_en;
    logic [SET_INDEX_BITS-1:0]      lru_set_index;
    logic [1:0]                     lru_way;
    logic                           ptw_req_valid;
    logic                           ptw_req_ready;
    logic [19:0]                    ptw_vpn;
    logic                           ptw_resp_valid;
    logic [19:0]                    ptw_ppn;
    logic [1:0]                     ptw_perms;
    logic                           ptw_fault;
    logic                           flush_req;
    logic                           flush_done;

    // Controller side
    modport slave (
        input  req_valid, req_vaddr, req_write, resp_ready,
        input  rd_valid, rd_vpn, rd_ppn, rd_perms, rd_lru_count,
        input  ptw_req_ready, ptw_resp_valid, ptw_ppn, ptw_perms, ptw_fault, flush_req,
        output req_ready, resp_valid, resp_paddr, resp_fault, rd_set_index,
        output wr_en, wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count,
        output lru_update_en, lru_set_index, lru_way, ptw_req_valid, ptw_vpn, flush_done
    );

    // Requester / storage / walker side
    modport master (
        output req_valid, req_vaddr, req_write, resp_ready,
        output rd_valid, rd_vpn, rd_ppn, rd_perms, rd_lru_count,
        output ptw_req_ready, ptw_resp_valid, ptw_ppn, ptw_perms, ptw_fault, flush_req,
        input  req_ready, resp_valid, resp_paddr, resp_fault, rd_set_index,
        input  wr_en, wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count,
        input  lru_update_en, lru_set_index, lru_way, ptw_req_valid, ptw_vpn, flush_done
    );
endinterface
`default_nettype wire

// File: rtl/tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ctrl
// Description : TLB lookup / miss-refill / flush controller in front of storage
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_ctrl #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    tlb_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_PTW_REQ  = 3'd2,
        S_PTW_WAIT = 3'd3,
        S_REFILL   = 3'd4,
        S_RESP     = 3'd5,
        S_FLUSH    = 3'd6
    } state_t;

    localparam logic [LRU_BITS-1:0] c_lru_max = '1;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_vaddr;
    logic                      r_write;
    logic [1:0]                r_way;
    logic [19:0]               r_ppn;
    logic [1:0]                r_perms;
    logic                      r_fault;
    logic [SET_INDEX_BITS-1:0] r_flush_set;
    logic [1:0]                r_flush_way;
    logic                      r_flush_done;

    logic [19:0]               w_vpn;
    logic [SET_INDEX_BITS-1:0] w_set;
    logic                      w_hit;
    logic [1:0]                w_hit_way;
    logic [19:0]               w_hit_ppn;
    logic [1:0]                w_hit_perms;
    logic [LRU_BITS-1:0]       w_hit_cnt;
    logic                      w_inv_found;
    logic [1:0]                w_inv_way;
    logic [1:0]                w_min_way;
    logic [LRU_BITS-1:0]       w_min_cnt;
    logic [1:0]                w_victim;
    logic                      w_hit_ok;
    logic                      w_walk_ok;
    logic                      w_flush_last;

    assign w_vpn = r_vaddr[31:12];
    assign w_set = r_vaddr[12 +: SET_INDEX_BITS];

    // Ascending scans give lowest-index priority for hit, invalid way and LRU ties
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = 2'd0;
        w_hit_ppn   = 20'd0;
        w_hit_perms = 2'd0;
        w_hit_cnt   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = 2'd0;
        w_min_way   = 2'd0;
        w_min_cnt   = bus.rd_lru_count[0 +: LRU_BITS];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_hit && bus.rd_valid[w] && (bus.rd_vpn[w*20 +: 20] == w_vpn)) begin
                w_hit       = 1'b1;
                w_hit_way   = 2'(w);
                w_hit_ppn   = bus.rd_ppn[w*20 +: 20];
                w_hit_perms = bus.rd_perms[w*2 +: 2];
                w_hit_cnt   = bus.rd_lru_count[w*LRU_BITS +: LRU_BITS];
            end
            if (!w_inv_found && !bus.rd_valid[w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = 2'(w);
            end
            if (bus.rd_lru_count[w*LRU_BITS +: LRU_BITS] < w_min_cnt) begin
                w_min_cnt = bus.rd_lru_count[w*LRU_BITS +: LRU_BITS];
                w_min_way = 2'(w);
            end
        end
    end

    assign w_victim     = w_inv_found ? w_inv_way : w_min_way;
    assign w_hit_ok     = r_write ? w_hit_perms[1] : w_hit_perms[0];
    assign w_walk_ok    = r_write ? r_perms[1] : r_perms[0];
    assign w_flush_last = (r_flush_way == 2'(NUM_WAYS - 1)) &&
                          (r_flush_set == SET_INDEX_BITS'(NUM_SETS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_paddr     = 32'd0;
        bus.resp_fault     = 1'b0;
        bus.rd_set_index   = '0;
        bus.wr_en          = 1'b0;
        bus.wr_set_index   = '0;
        bus.wr_way         = 2'd0;
        bus.wr_valid       = 1'b0;
        bus.wr_vpn         = 20'd0;
        bus.wr_ppn         = 20'd0;
        bus.wr_perms       = 2'd0;
        bus.wr_lru_count   = '0;
        bus.lru_update_en  = 1'b0;
        bus.lru_set_index  = '0;
        bus.lru_way        = 2'd0;
        bus.ptw_req_valid  = 1'b0;
        bus.ptw_vpn        = 20'd0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = rst_n & ~bus.flush_req;
                if (bus.flush_req) begin
                    w_next = S_FLUSH;
                end else if (bus.req_valid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                bus.rd_set_index = w_set;
                if (w_hit) begin
                    // The storage counter saturates; never ask it to wrap
                    if (w_hit_ok && (w_hit_cnt != c_lru_max)) begin
                        bus.lru_update_en = 1'b1;
                        bus.lru_set_index = w_set;
                        bus.lru_way       = w_hit_way;
                    end
                    w_next = S_RESP;
                end else begin
                    w_next = S_PTW_REQ;
                end
            end
            S_PTW_REQ: begin
                bus.ptw_req_valid = 1'b1;
                bus.ptw_vpn       = w_vpn;
                if (bus.ptw_req_ready) begin
                    w_next = S_PTW_WAIT;
                end
            end
            S_PTW_WAIT: begin
                if (bus.ptw_resp_valid) begin
                    w_next = bus.ptw_fault ? S_RESP : S_REFILL;
                end
            end
            S_REFILL: begin
                bus.wr_en        = 1'b1;
                bus.wr_set_index = w_set;
                bus.wr_way       = r_way;
                bus.wr_valid     = 1'b1;
                bus.wr_vpn       = w_vpn;
                bus.wr_ppn       = r_ppn;
                bus.wr_perms     = r_perms;
                bus.wr_lru_count = LRU_BITS'(1);
                w_next           = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = r_fault;
                bus.resp_paddr = r_fault ? 32'd0 : {r_ppn, r_vaddr[11:0]};
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                bus.wr_en        = 1'b1;
                bus.wr_set_index = r_flush_set;
                bus.wr_way       = r_flush_way;
                if (w_flush_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vaddr      <= 32'd0;
            r_write      <= 1'b0;
            r_way        <= 2'd0;
            r_ppn        <= 20'd0;
            r_perms      <= 2'd0;
            r_fault      <= 1'b0;
            r_flush_set  <= '0;
            r_flush_way  <= 2'd0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= (r_state == S_FLUSH) && w_flush_last;
            case (r_state)
                S_IDLE: begin
                    r_flush_set <= '0;
                    r_flush_way <= 2'd0;
                    if (!bus.flush_req && bus.req_valid) begin
                        r_vaddr <= bus.req_vaddr;
                        r_write <= bus.req_write;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_ppn   <= w_hit_ppn;
                        r_fault <= ~w_hit_ok;
                    end else begin
                        r_way   <= w_victim;
                        r_fault <= 1'b0;
                    end
                end
                S_PTW_WAIT: begin
                    if (bus.ptw_resp_valid) begin
                        if (bus.ptw_fault) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_ppn   <= bus.ptw_ppn;
                            r_perms <= bus.ptw_perms;
                        end
                    end
                end
                S_REFILL: r_fault <= ~w_walk_ok;
                S_FLUSH: begin
                    if (r_flush_way == 2'(NUM_WAYS - 1)) begin
                        r_flush_way <= 2'd0;
                        r_flush_set <= r_flush_set + 1'b1;
                    end else begin
                        r_flush_way <= r_flush_way + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.flush_done = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_ctrl
// Description : Directed scoreboard bench for tlb_ctrl with a TLB storage model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_ctrl;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int SB = 4;
    localparam int LB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_ctrl_if #(.NUM_WAYS(NW), .SET_INDEX_BITS(SB), .LRU_BITS(LB)) bus ();

    tlb_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .SET_INDEX_BITS(SB), .LRU_BITS(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Storage model: combinational read, write and LRU increment on the clock
    logic          m_valid [NS][NW];
    logic [19:0]   m_vpn   [NS][NW];
    logic [19:0]   m_ppn   [NS][NW];
    logic [1:0]    m_perms [NS][NW];
    logic [LB-1:0] m_lru   [NS][NW];
    logic          clr = 1'b0;
    logic          pre_en = 1'b0;
    logic [SB-1:0] pre_set = '0;
    logic [1:0]    pre_way = '0;
    logic [19:0]   pre_vpn = '0;
    logic [19:0]   pre_ppn = '0;
    logic [1:0]    pre_perms = '0;
    logic [LB-1:0] pre_lru = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < NS; s++) begin
                for (int w = 0; w < NW; w++) begin
                    m_valid[s][w] <= 1'b0; m_vpn[s][w] <= '0; m_ppn[s][w] <= '0;
                    m_perms[s][w] <= '0;   m_lru[s][w] <= '0;
                end
            end
        end else begin
            if (bus.wr_en) begin
                m_valid[bus.wr_set_index][bus.wr_way] <= bus.wr_valid;
                m_vpn[bus.wr_set_index][bus.wr_way]   <= bus.wr_vpn;
                m_ppn[bus.wr_set_index][bus.wr_way]   <= bus.wr_ppn;
                m_perms[bus.wr_set_index][bus.wr_way] <= bus.wr_perms;
                m_lru[bus.wr_set_index][bus.wr_way]   <= bus.wr_lru_count;
            end
            if (bus.lru_update_en)
                m_lru[bus.lru_set_index][bus.lru_way] <= m_lru[bus.lru_set_index][bus.lru_way] + 1'b1;
            if (pre_en) begin
                m_valid[pre_set][pre_way] <= 1'b1;     m_vpn[pre_set][pre_way] <= pre_vpn;
                m_ppn[pre_set][pre_way]   <= pre_ppn;  m_perms[pre_set][pre_way] <= pre_perms;
                m_lru[pre_set][pre_way]   <= pre_lru;
            end
        end
    end

    always_comb begin
        bus.rd_valid     = '0;
        bus.rd_vpn       = '0;
        bus.rd_ppn       = '0;
        bus.rd_perms     = '0;
        bus.rd_lru_count = '0;
        for (int w = 0; w < NW; w++) begin
            bus.rd_valid[w]              = m_valid[bus.rd_set_index][w];
            bus.rd_vpn[w*20 +: 20]       = m_vpn[bus.rd_set_index][w];
            bus.rd_ppn[w*20 +: 20]       = m_ppn[bus.rd_set_index][w];
            bus.rd_perms[w*2 +: 2]       = m_perms[bus.rd_set_index][w];
            bus.rd_lru_count[w*LB +: LB] = m_lru[bus.rd_set_index][w];
        end
    end

    // Event monitor
    int          cyc = 0, n_wr = 0, n_lru = 0, n_ptw = 0, n_fwr = 0, n_fbad = 0, n_coll = 0;
    logic [63:0] fcov = '0;
    always @(posedge clk) begin
        cyc++;
        if (bus.wr_en) n_wr++;
        if (bus.lru_update_en) n_lru++;
        if (bus.wr_en && bus.lru_update_en) n_coll++;
        if (bus.ptw_req_valid && bus.ptw_req_ready) n_ptw++;
        if (bus.wr_en && !bus.wr_valid) begin
            n_fwr++;
            fcov[{bus.wr_set_index, bus.wr_way}] = 1'b1;
            if ((bus.wr_vpn | bus.wr_ppn) != 20'd0 || bus.wr_perms != 2'd0 || bus.wr_lru_count != '0)
                n_fbad++;
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] sb[$];   // {fault, paddr}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.req_ready;
            1:       return bus.ptw_req_valid;
            2:       return bus.resp_valid;
            3:       return bus.flush_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = sig(which);
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic send(input logic [31:0] va, input logic wr, input logic [31:0] ep, input logic ef);
        wait_sig(0, "wait_req_ready");
        bus.req_vaddr = va;
        bus.req_write = wr;
        bus.req_valid = 1'b1;
        sb.push_back({ef, ep});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic walk(input logic [19:0] evpn, input logic [19:0] ppn, input logic [1:0] perms, input logic flt);
        wait_sig(1, "wait_ptw_req");
        check("ptw_vpn", 64'(bus.ptw_vpn), 64'(evpn));
        bus.ptw_req_ready = 1'b1;
        @(negedge clk);
        bus.ptw_req_ready  = 1'b0;
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_ppn        = ppn;
        bus.ptw_perms      = perms;
        bus.ptw_fault      = flt;
        @(negedge clk);
        bus.ptw_resp_valid = 1'b0;
    endtask

    task automatic take_resp(input int hold);
        logic [32:0] e;
        wait_sig(2, "wait_resp_valid");
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < hold; i++) begin
                check("resp_hold", 64'({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.resp_paddr}),
                      64'({1'b0, 1'b1, e[32], e[31:0]}));
                @(negedge clk);
            end
            check("resp_paddr", 64'(bus.resp_paddr), 64'(e[31:0]));
            check("resp_fault", 64'(bus.resp_fault), 64'(e[32]));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic preset(input logic [SB-1:0] s, input logic [1:0] w, input logic [19:0] vpn,
                          input logic [19:0] ppn, input logic [1:0] perms, input logic [LB-1:0] lru);
        @(negedge clk);
        pre_set = s; pre_way = w; pre_vpn = vpn; pre_ppn = ppn; pre_perms = perms; pre_lru = lru;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    int            p0, l0, w0, c0;
    logic [LB-1:0] cnts [4] = '{4'd3, 4'd1, 4'd1, 4'd5};

    initial begin
        bus.req_valid = 0; bus.req_vaddr = 0; bus.req_write = 0; bus.resp_ready = 0;
        bus.ptw_req_ready = 0; bus.ptw_resp_valid = 0; bus.ptw_ppn = 0; bus.ptw_perms = 0;
        bus.ptw_fault = 0; bus.flush_req = 0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_outputs", 64'({bus.resp_valid, bus.wr_en, bus.lru_update_en, bus.ptw_req_valid,
                                  bus.flush_done, bus.resp_paddr}), 64'd0);
        rst_n = 1'b1;
        #1 check("req_ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Cold miss
        send(32'h0001_2345, 1'b0, 32'hABCD_E345, 1'b0);
        walk(20'h00012, 20'hABCDE, 2'b01, 1'b0);
        check("refill_ctl", 64'({bus.wr_en, bus.wr_valid, bus.wr_set_index, bus.wr_way, bus.wr_lru_count}),
              64'({1'b1, 1'b1, 4'd2, 2'd0, 4'd1}));
        check("refill_data", 64'({bus.wr_vpn, bus.wr_ppn, bus.wr_perms}), 64'({20'h00012, 20'hABCDE, 2'b01}));
        @(negedge clk);
        check("miss_resp_latency", 64'(bus.resp_valid), 64'd1);
        take_resp(0);

        // Hit on the same page
        p0 = n_ptw;
        send(32'h0001_2345, 1'b0, 32'hABCD_E345, 1'b0);
        @(negedge clk);
        check("hit_lru_pulse", 64'({bus.lru_update_en, bus.lru_set_index, bus.lru_way}), 64'({1'b1, 4'd2, 2'd0}));
        @(negedge clk);
        check("hit_resp_latency", 64'(bus.resp_valid), 64'd1);
        take_resp(0);
        check("hit_no_ptw", 64'(n_ptw), 64'(p0));

        // Store to a read-only page
        l0 = n_lru;
        send(32'h0001_2345, 1'b1, 32'd0, 1'b1);
        @(negedge clk);
        check("perm_fault_no_lru", 64'(bus.lru_update_en), 64'd0);
        take_resp(0);
        check("perm_fault_lru_count", 64'(n_lru), 64'(l0));

        // Full set 5, counts {3,1,1,5}: victim is way 1
        for (int w = 0; w < 4; w++)
            preset(4'd5, 2'(w), {4'(w + 1), 16'h0005}, 20'h0C0D0 + 20'(w), 2'b11, cnts[w]);
        send(32'h0055_5ABC, 1'b0, 32'h1234_5ABC, 1'b0);
        walk(20'h00555, 20'h12345, 2'b11, 1'b0);
        check("victim_way", 64'({bus.wr_en, bus.wr_set_index, bus.wr_way}), 64'({1'b1, 4'd5, 2'd1}));
        take_resp(0);

        send(32'h4000_5010, 1'b0, 32'h0C0D_3010, 1'b0);
        @(negedge clk);
        check("hit_way3_lru", 64'({bus.lru_update_en, bus.lru_set_index, bus.lru_way}), 64'({1'b1, 4'd5, 2'd3}));
        take_resp(0);

        // Saturated counter: no LRU pulse
        preset(4'd5, 2'd2, 20'h30005, 20'h0C0D2, 2'b11, 4'hF);
        l0 = n_lru;
        send(32'h3000_5010, 1'b0, 32'h0C0D_2010, 1'b0);
        @(negedge clk);
        check("sat_no_lru", 64'(bus.lru_update_en), 64'd0);
        take_resp(0);
        check("sat_lru_count", 64'(n_lru), 64'(l0));

        // Walk fault with a stalled response
        w0 = n_wr;
        send(32'h0007_7000, 1'b1, 32'd0, 1'b1);
        walk(20'h00077, 20'h55555, 2'b11, 1'b1);
        check("walk_fault_latency", 64'(bus.resp_valid), 64'd1);
        take_resp(5);
        check("walk_fault_no_wr", 64'(n_wr), 64'(w0));

        // Flush
        wait_sig(0, "flush_wait_idle");
        bus.flush_req = 1'b1;
        #1 check("flush_blocks_req", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        c0 = cyc;
        bus.flush_req = 1'b0;
        wait_sig(3, "wait_flush_done");
        check("flush_latency", 64'(cyc - (c0 - 1)), 64'd65);
        check("flush_write_count", 64'(n_fwr), 64'd64);
        check("flush_coverage", fcov, 64'hFFFF_FFFF_FFFF_FFFF);
        check("flush_zero_fields", 64'(n_fbad), 64'd0);

        // Flushed entry misses; reset during the walk aborts it
        send(32'h0001_2345, 1'b0, 32'd0, 1'b0);
        wait_sig(1, "post_flush_miss");
        bus.ptw_req_ready = 1'b1;
        @(negedge clk);
        bus.ptw_req_ready = 1'b0;
        w0 = n_wr;
        l0 = n_lru;
        rst_n = 1'b0;
        #1 check("rst_mid_walk_outputs", 64'({bus.req_ready, bus.resp_valid, bus.ptw_req_valid,
                                              bus.wr_en, bus.lru_update_en, bus.flush_done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ptw_resp_valid = 1'b1; bus.ptw_ppn = 20'hABCDE; bus.ptw_perms = 2'b11; bus.ptw_fault = 1'b0;
        @(negedge clk);
        bus.ptw_resp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_write", 64'({32'(n_wr), 32'(n_lru)}), 64'({32'(w0), 32'(l0)}));
        check("rst_idle", 64'({bus.resp_valid, bus.req_ready}), 64'({1'b0, 1'b1}));
        void'(sb.pop_back());

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("no_wr_lru_collision", 64'(n_coll), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
